// File: rtl/calc_sequencer.sv
// Command sequencer: collects two keypad digits into R0/R1, runs the ALU on them
// and writes the 8-bit result back to the destination register.
module calc_sequencer #(
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_dst,
  input  logic       abort,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       reg_wr_en,
  output logic [1:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic [1:0] reg_rd_addr_a,
  output logic [1:0] reg_rd_addr_b,
  output logic [1:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic [7:0] result,
  output logic       zero_out,
  output logic       carry_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_A    = 3'd1,
    S_WAIT_B    = 3'd2,
    S_SETTLE    = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITEBACK = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;
  logic [1:0]  dst_q;
  logic        accept;
  logic        capture;
  logic        timeout_hit;
  logic        wr_en_n;
  logic [1:0]  wr_addr_n;
  logic [7:0]  wr_data_n;
  logic        done_n;
  logic        err_n;

  // Command handshake: a command transfers on any edge where cmd_valid && cmd_ready.
  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign accept        = cmd_valid && cmd_ready;
  assign reg_rd_addr_a = 2'd0;
  assign reg_rd_addr_b = 2'd1;
  assign dbg_state     = state;
  assign timeout_hit   = (TIMEOUT != 24'd0) && (cnt == TIMEOUT - 24'd1);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    wr_en_n   = 1'b0;
    wr_addr_n = reg_wr_addr;
    wr_data_n = reg_wr_data;
    done_n    = 1'b0;
    err_n     = 1'b0;
    capture   = 1'b0;
    // abort outranks every other event, so no write or capture follows it
    if (state != S_IDLE && abort) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state_n = S_WAIT_A;
            cnt_n   = 24'd0;
          end
        end
        S_WAIT_A, S_WAIT_B: begin
          if (key_valid) begin
            state_n   = (state == S_WAIT_A) ? S_WAIT_B : S_SETTLE;
            cnt_n     = 24'd0;
            wr_en_n   = 1'b1;
            wr_addr_n = (state == S_WAIT_A) ? 2'd0 : 2'd1;
            wr_data_n = {4'b0000, key_code};
          end else if (timeout_hit) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
          end else begin
            cnt_n = cnt + 24'd1;
          end
        end
        S_SETTLE: state_n = S_EXEC;
        S_EXEC: begin
          state_n   = S_WRITEBACK;
          capture   = 1'b1;
          wr_en_n   = 1'b1;
          wr_addr_n = dst_q;
          wr_data_n = alu_result;
        end
        S_WRITEBACK: begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 24'd0;
      dst_q       <= 2'd0;
      alu_op      <= 2'd0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= 2'd0;
      reg_wr_data <= 8'd0;
      result      <= 8'd0;
      zero_out    <= 1'b0;
      carry_out   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      reg_wr_en   <= wr_en_n;
      reg_wr_addr <= wr_addr_n;
      reg_wr_data <= wr_data_n;
      done        <= done_n;
      err         <= err_n;
      if (accept) begin
        alu_op <= cmd_op;
        dst_q  <= cmd_dst;
      end
      if (capture) begin
        result    <= alu_result;
        zero_out  <= alu_zero;
        carry_out <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: models the register bank and ALU around the DUT and
// checks write strobes, captured flags and handshake timing against fixed vectors.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_dst;
  logic       abort;
  logic       key_valid;
  logic [3:0] key_code;
  logic       reg_wr_en;
  logic [1:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic [1:0] reg_rd_addr_a;
  logic [1:0] reg_rd_addr_b;
  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;
  logic [7:0] result;
  logic       zero_out;
  logic       carry_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_sequencer #(.TIMEOUT(24'd16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .abort(abort), .key_valid(key_valid),
    .key_code(key_code), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_addr_a(reg_rd_addr_a),
    .reg_rd_addr_b(reg_rd_addr_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .result(result),
    .zero_out(zero_out), .carry_out(carry_out), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // Register bank and ALU: add, subtract (carry = borrow), and, or
  logic [7:0] bank [4];
  logic [8:0] alu_full;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) bank[i] <= 8'd0;
    end else if (reg_wr_en) begin
      bank[reg_wr_addr] <= reg_wr_data;
    end
  end

  always_comb begin
    alu_full = 9'd0;
    case (alu_op)
      2'd0: alu_full = {1'b0, bank[reg_rd_addr_a]} + {1'b0, bank[reg_rd_addr_b]};
      2'd1: alu_full = {1'b0, bank[reg_rd_addr_a]} - {1'b0, bank[reg_rd_addr_b]};
      2'd2: alu_full = {1'b0, bank[reg_rd_addr_a] & bank[reg_rd_addr_b]};
      default: alu_full = {1'b0, bank[reg_rd_addr_a] | bank[reg_rd_addr_b]};
    endcase
  end

  assign alu_result = alu_full[7:0];
  assign alu_carry  = alu_full[8];
  assign alu_zero   = (alu_full[7:0] == 8'd0);

  typedef struct {
    logic [1:0] op;
    logic [1:0] dst;
    logic [3:0] a;
    logic [3:0] b;
    int         gap_b;
    logic [7:0] res;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full command; stray drives key_valid during SETTLE and EXEC, hold keeps cmd_valid high.
  task automatic run_cmd(input vec_t v, input bit hold, input bit stray);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_dst   = v.dst;
    tick();
    if (!hold) cmd_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_state", dbg_state, 1);
    tick();
    tick();
    key_valid = 1'b1;
    key_code  = v.a;
    tick();
    key_valid = 1'b0;
    check("r0_wr_en", reg_wr_en, 1);
    check("r0_wr_addr", reg_wr_addr, 0);
    check("r0_wr_data", reg_wr_data, {4'b0000, v.a});
    for (int i = 0; i < v.gap_b; i++) tick();
    key_valid = 1'b1;
    key_code  = v.b;
    tick();
    key_valid = stray;
    key_code  = 4'hE;
    check("r1_wr_en", reg_wr_en, 1);
    check("r1_wr_addr", reg_wr_addr, 1);
    check("r1_wr_data", reg_wr_data, {4'b0000, v.b});
    tick();
    check("exec_no_wr", reg_wr_en, 0);
    check("exec_state", dbg_state, 4);
    tick();
    key_valid = 1'b0;
    check("wb_wr_en", reg_wr_en, 1);
    check("wb_wr_addr", reg_wr_addr, v.dst);
    check("wb_wr_data", reg_wr_data, v.res);
    check("result", result, v.res);
    check("zero_out", zero_out, v.z);
    check("carry_out", carry_out, v.c);
    tick();
    check("done_pulse", done, 1);
    check("done_no_wr", reg_wr_en, 0);
    check("done_busy", busy, 1);
    tick();
    check("done_clear", done, 0);
    check("ready_back", cmd_ready, 1);
    check("idle_no_wr", reg_wr_en, 0);
  endtask

  initial begin
    int  n;
    bit  saw_wr;

    vecs[0] = '{op: 2'd0, dst: 2'd2, a: 4'h3, b: 4'h5, gap_b: 1, res: 8'h08, z: 1'b0, c: 1'b0};
    vecs[1] = '{op: 2'd1, dst: 2'd3, a: 4'h7, b: 4'h7, gap_b: 2, res: 8'h00, z: 1'b1, c: 1'b0};
    vecs[2] = '{op: 2'd0, dst: 2'd0, a: 4'hF, b: 4'hF, gap_b: 0, res: 8'h1E, z: 1'b0, c: 1'b0};
    vecs[3] = '{op: 2'd1, dst: 2'd1, a: 4'h2, b: 4'h5, gap_b: 1, res: 8'hFD, z: 1'b0, c: 1'b1};
    vecs[4] = '{op: 2'd2, dst: 2'd2, a: 4'hC, b: 4'hA, gap_b: 3, res: 8'h08, z: 1'b0, c: 1'b0};
    vecs[5] = '{op: 2'd3, dst: 2'd3, a: 4'h0, b: 4'h0, gap_b: 0, res: 8'h00, z: 1'b1, c: 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dst = 2'd0;
    abort = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_wr_addr", reg_wr_addr, 0);
    check("rst_wr_data", reg_wr_data, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_result", {zero_out, carry_out, result}, 0);
    check("rd_addr_a", reg_rd_addr_a, 0);
    check("rd_addr_b", reg_rd_addr_b, 1);

    for (int i = 0; i < 6; i++) run_cmd(vecs[i], 1'b0, 1'b0);

    // abort and key in IDLE are ignored
    abort = 1'b1; key_valid = 1'b1; key_code = 4'h9;
    tick();
    abort = 1'b0; key_valid = 1'b0;
    check("idle_abort_err", err, 0);
    check("idle_key_no_wr", reg_wr_en, 0);
    check("idle_stays", cmd_ready, 1);

    // timeout with no keys
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dst = 2'd2;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    saw_wr = 1'b0;
    while (!err && n < 40) begin
      saw_wr |= reg_wr_en;
      tick();
      n++;
    end
    check("timeout_cycles", n, 16);
    check("timeout_no_wr", saw_wr, 0);
    check("timeout_ready", cmd_ready, 1);
    tick();
    check("timeout_err_once", err, 0);
    check("timeout_ready_next", cmd_ready, 1);

    // abort together with key B
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dst = 2'd3;
    tick();
    cmd_valid = 1'b0;
    key_valid = 1'b1; key_code = 4'h4;
    tick();
    key_valid = 1'b0;
    check("abort_r0_wr", reg_wr_en, 1);
    tick();
    key_valid = 1'b1; key_code = 4'h6; abort = 1'b1;
    tick();
    key_valid = 1'b0; abort = 1'b0;
    check("abort_err", err, 1);
    check("abort_no_r1_wr", reg_wr_en, 0);
    check("abort_idle", cmd_ready, 1);
    tick();
    check("abort_err_once", err, 0);
    check("abort_no_late_wr", reg_wr_en, 0);
    run_cmd(vecs[0], 1'b0, 1'b0);

    // cmd_valid held across DONE, stray keys in SETTLE/EXEC
    run_cmd(vecs[3], 1'b1, 1'b1);
    check("held_not_busy", busy, 0);
    tick();
    cmd_valid = 1'b0;
    check("held_second_accept", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("held_abort_err", err, 1);
    check("held_abort_no_wr", reg_wr_en, 0);

    // reset while in EXEC
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dst = 2'd3;
    tick();
    cmd_valid = 1'b0;
    key_valid = 1'b1; key_code = 4'h1;
    tick();
    key_code = 4'h2;
    tick();
    key_valid = 1'b0;
    tick();
    check("pre_reset_exec", dbg_state, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr", {reg_wr_en, reg_wr_addr, reg_wr_data}, 0);
    check("mid_rst_result", {zero_out, carry_out, result}, 0);
    check("mid_rst_flags", {done, err, alu_op}, 0);
    tick();
    check("mid_rst_no_wb", reg_wr_en, 0);
    check("mid_rst_no_done", done, 0);
    check("mid_rst_result_hold", result, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
